// File: rtl/regfile_bist_pkg.sv
// Shared types for the register-file March C- BIST controller: FSM states,
// March elements, access ops and the per-element direction/background table.
package regfile_bist_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    typedef enum logic [2:0] {E0, E1, E2, E3, E4, E5} elem_t;

    typedef enum logic {OP_READ, OP_WRITE} op_t;

    typedef struct packed {
        logic down;
        logic has_rd;
        logic rd_bg;
        logic has_wr;
        logic wr_bg;
    } elem_cfg_t;

    // March C-: up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) up(r0)
    function automatic elem_cfg_t elem_cfg(elem_t e);
        case (e)
            E0:      return '{down: 1'b0, has_rd: 1'b0, rd_bg: 1'b0, has_wr: 1'b1, wr_bg: 1'b0};
            E1:      return '{down: 1'b0, has_rd: 1'b1, rd_bg: 1'b0, has_wr: 1'b1, wr_bg: 1'b1};
            E2:      return '{down: 1'b0, has_rd: 1'b1, rd_bg: 1'b1, has_wr: 1'b1, wr_bg: 1'b0};
            E3:      return '{down: 1'b1, has_rd: 1'b1, rd_bg: 1'b0, has_wr: 1'b1, wr_bg: 1'b1};
            E4:      return '{down: 1'b1, has_rd: 1'b1, rd_bg: 1'b1, has_wr: 1'b1, wr_bg: 1'b0};
            default: return '{down: 1'b0, has_rd: 1'b1, rd_bg: 1'b0, has_wr: 1'b0, wr_bg: 1'b0};
        endcase
    endfunction

    function automatic op_t first_op(elem_cfg_t c);
        return c.has_rd ? OP_READ : OP_WRITE;
    endfunction

endpackage

// File: rtl/regfile_bist_if.sv
// Register-file test port: controller drives the access, the wrapper returns Q_T.
interface regfile_bist_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  BIST;
    logic                  CSN_T;
    logic                  WEN_T;
    logic [ADDR_WIDTH-1:0] A_T;
    logic [DATA_WIDTH-1:0] D_T;
    logic [DATA_WIDTH-1:0] Q_T;

    modport master (output BIST, CSN_T, WEN_T, A_T, D_T, input Q_T);
    modport slave  (input BIST, CSN_T, WEN_T, A_T, D_T, output Q_T);
endinterface

// File: rtl/regfile_bist_addr_gen.sv
// Loadable up/down address counter over 0..M-1 with an end-of-sweep flag.
module regfile_bist_addr_gen #(
    parameter int AW = 5,
    parameter int M  = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          load_down,
    input  logic          step,
    output logic [AW-1:0] addr,
    output logic          last
);

    logic down;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
            down <= 1'b0;
        end else if (load) begin
            down <= load_down;
            addr <= load_down ? AW'(M - 1) : '0;
        end else if (step) begin
            addr <= down ? addr - 1'b1 : addr + 1'b1;
        end
    end

    // The controller reloads on last, so the counter never reaches address M.
    assign last = down ? (addr == '0) : (addr == AW'(M - 1));

endmodule

// File: rtl/regfile_bist_ctrl.sv
// March C- BIST controller for a register file behind a test wrapper.
// state | meaning
// IDLE  | waiting for start_i after reset
// RUN   | one test access per cycle, compares trail reads by one cycle
// DRAIN | compare of the final E5 read
// DONE  | result held until next start_i
module regfile_bist_ctrl
    import regfile_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    regfile_bist_if.master        tp,
    output logic                  done_o,
    output logic                  fail_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [2:0]            fail_elem_o
);

    localparam int M = 2 ** (ADDR_WIDTH - 1) - 1;

    state_t                state, state_nx;
    elem_t                 elem, elem_nx;
    op_t                   op, op_nx;
    elem_cfg_t             cfg, cfg_nx;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  addr_last, ag_load, ag_load_down, ag_step;
    logic                  run, addr_done, start_acc;
    logic                  cmp_vld, cmp_bg, mismatch;
    logic [ADDR_WIDTH-1:0] cmp_addr;
    elem_t                 cmp_elem;

    regfile_bist_addr_gen #(.AW(ADDR_WIDTH), .M(M)) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (ag_load),
        .load_down (ag_load_down),
        .step      (ag_step),
        .addr      (addr),
        .last      (addr_last)
    );

    assign cfg       = elem_cfg(elem);
    assign run       = (state == ST_RUN);
    assign addr_done = run && (op == OP_WRITE || !cfg.has_wr);
    assign start_acc = start_i && (state == ST_IDLE || state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            elem  <= E0;
            op    <= OP_WRITE;
        end else begin
            state <= state_nx;
            elem  <= elem_nx;
            op    <= op_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        elem_nx      = elem;
        op_nx        = op;
        cfg_nx       = cfg;
        ag_load      = 1'b0;
        ag_load_down = 1'b0;
        ag_step      = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_nx = ST_RUN;
                    elem_nx  = E0;
                    op_nx    = first_op(elem_cfg(E0));
                    ag_load  = 1'b1;
                end
            end
            ST_RUN: begin
                if (addr_done) begin
                    if (addr_last) begin
                        if (elem == E5) begin
                            state_nx = ST_DRAIN;
                        end else begin
                            elem_nx      = elem_t'(elem + 3'd1);
                            cfg_nx       = elem_cfg(elem_nx);
                            op_nx        = first_op(cfg_nx);
                            ag_load      = 1'b1;
                            ag_load_down = cfg_nx.down;
                        end
                    end else begin
                        ag_step = 1'b1;
                        op_nx   = first_op(cfg);
                    end
                end else begin
                    op_nx = OP_WRITE;
                end
            end
            ST_DRAIN: state_nx = ST_DONE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Read pipeline: Q_T arrives one cycle after the read request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_vld  <= 1'b0;
            cmp_bg   <= 1'b0;
            cmp_addr <= '0;
            cmp_elem <= E0;
        end else begin
            cmp_vld  <= run && (op == OP_READ);
            cmp_bg   <= cfg.rd_bg;
            cmp_addr <= addr;
            cmp_elem <= elem;
        end
    end

    assign mismatch = cmp_vld && (tp.Q_T != {DATA_WIDTH{cmp_bg}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_o      <= 1'b0;
            fail_addr_o <= '0;
            fail_elem_o <= 3'd0;
        end else if (start_acc) begin
            fail_o      <= 1'b0;
            fail_addr_o <= '0;
            fail_elem_o <= 3'd0;
        end else if (mismatch && !fail_o) begin
            fail_o      <= 1'b1;
            fail_addr_o <= cmp_addr;
            fail_elem_o <= cmp_elem;
        end
    end

    assign done_o   = (state == ST_DONE);
    assign tp.BIST  = run || (state == ST_DRAIN);
    assign tp.CSN_T = !run;
    assign tp.WEN_T = !(run && op == OP_WRITE);
    assign tp.A_T   = run ? addr : '0;
    assign tp.D_T   = (run && op == OP_WRITE) ? {DATA_WIDTH{cfg.wr_bg}} : '0;

endmodule

// File: tb/tb_regfile_bist_ctrl.sv
// Scoreboard bench: register-file model behind a reversing test wrapper, expected
// March accesses and run results queued at stimulus, checked by monitors.
module tb_regfile_bist_ctrl;

    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int M   = 15;
    localparam int LAT = 10 * M + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_i = 1'b0;
    logic          done_o, fail_o;
    logic [AW-1:0] fail_addr_o;
    logic [2:0]    fail_elem_o;

    regfile_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) tp ();

    regfile_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .tp          (tp),
        .done_o      (done_o),
        .fail_o      (fail_o),
        .fail_addr_o (fail_addr_o),
        .fail_elem_o (fail_elem_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } acc_t;

    typedef struct {
        int            start_cyc;
        bit            fail;
        logic [AW-1:0] faddr;
        logic [2:0]    felem;
    } res_t;

    acc_t          acc_q[$];
    res_t          res_q[$];
    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            runs_done = 0;
    int            acc_total = 0;
    bit            stuck_en = 1'b0;
    logic          done_prev = 1'b0;
    logic [DW-1:0] mem [16];
    logic [DW-1:0] q = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Wrapper maps logical address a to physical register 15-a; register 0 reads 0.
    function automatic logic [3:0] phys_of(input logic [3:0] a);
        return 4'd15 - a;
    endfunction

    function automatic logic [DW-1:0] rd_model(input logic [3:0] p);
        logic [DW-1:0] d;
        d = (p == 4'd0) ? '0 : mem[p];
        if (stuck_en && p == 4'd5) d[3] = 1'b1;
        return d;
    endfunction

    always @(posedge clk) begin
        if (!tp.CSN_T) begin
            if (!tp.WEN_T) begin
                if (phys_of(tp.A_T[3:0]) != 4'd0) mem[phys_of(tp.A_T[3:0])] <= tp.D_T;
            end else begin
                q <= rd_model(phys_of(tp.A_T[3:0]));
            end
        end
    end

    assign tp.Q_T = q;

    always @(negedge clk) begin : mon
        acc_t e;
        res_t r;
        if (!rst && !tp.CSN_T) begin
            acc_total++;
            if (acc_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_access: got A_T=%0d WEN_T=%0b expected no access", tp.A_T, tp.WEN_T);
            end else begin
                e = acc_q.pop_front();
                check("access_wen", 64'(tp.WEN_T), 64'(!e.wr));
                check("access_addr", 64'(tp.A_T), 64'(e.a));
                if (e.wr) check("access_data", 64'(tp.D_T), 64'(e.d));
                check("bist_in_run", 64'(tp.BIST), 64'd1);
            end
        end
        if (done_o && !done_prev) begin
            if (res_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done_o=1 expected 0");
            end else begin
                r = res_q.pop_front();
                check("done_latency", 64'(cyc - r.start_cyc + 1), 64'(LAT));
                check("fail_o", 64'(fail_o), 64'(r.fail));
                check("fail_addr_o", 64'(fail_addr_o), 64'(r.faddr));
                check("fail_elem_o", 64'(fail_elem_o), 64'(r.felem));
                check("bist_in_done", 64'(tp.BIST), 64'd0);
            end
            runs_done++;
        end
        done_prev = done_o;
    end

    task automatic push_accesses(input int limit);
        int cnt;
        cnt = 0;
        for (int el = 0; el < 6; el++) begin
            for (int i = 0; i < M; i++) begin
                bit dn, rbg, wbg;
                int a;
                dn  = (el == 3 || el == 4);
                rbg = (el == 2 || el == 4);
                wbg = (el == 1 || el == 3);
                a   = dn ? (M - 1 - i) : i;
                if (el != 0 && cnt < limit) begin
                    acc_q.push_back('{wr: 1'b0, a: AW'(a), d: '0});
                    cnt++;
                end
                if (el != 5 && cnt < limit) begin
                    acc_q.push_back('{wr: 1'b1, a: AW'(a), d: {DW{wbg}}});
                    cnt++;
                end
            end
        end
    endtask

    // Returns just after the edge that samples start_i (cycle 1 of the run).
    task automatic start_run(input bit hold, input bit push_res, input bit efail,
                             input logic [AW-1:0] eaddr, input logic [2:0] eelem);
        @(negedge clk);
        start_i   = 1'b1;
        acc_total = 0;
        if (push_res) res_q.push_back('{start_cyc: cyc + 1, fail: efail, faddr: eaddr, felem: eelem});
        @(posedge clk);
        #1;
        if (!hold) start_i = 1'b0;
    endtask

    task automatic wait_done(input int prev);
        for (int i = 0; i < LAT + 50 && runs_done == prev; i++) @(posedge clk);
        if (runs_done == prev) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done_o expected done within %0d cycles", LAT + 50);
        end
    endtask

    initial begin
        int prev;
        for (int i = 0; i < 16; i++) mem[i] = 32'h5A5A_0000 + 32'(i);
        rst = 1'b1;
        #7;
        check("rst_bist", 64'(tp.BIST), 64'd0);
        check("rst_csn", 64'(tp.CSN_T), 64'd1);
        check("rst_wen", 64'(tp.WEN_T), 64'd1);
        check("rst_addr", 64'(tp.A_T), 64'd0);
        check("rst_data", 64'(tp.D_T), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_fail", 64'({fail_o, fail_addr_o, fail_elem_o}), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // clean run
        prev = runs_done;
        push_accesses(1000);
        start_run(1'b0, 1'b1, 1'b0, 5'd0, 3'd0);
        wait_done(prev);
        check("clean_access_count", 64'(acc_total), 64'd150);
        repeat (5) @(negedge clk);
        check("done_hold", 64'(done_o), 64'd1);
        check("clean_queue_empty", 64'(acc_q.size()), 64'd0);

        // stuck-at-1 on physical register 5 bit 3 (logical 10)
        stuck_en = 1'b1;
        prev = runs_done;
        push_accesses(1000);
        start_run(1'b0, 1'b1, 1'b1, 5'd10, 3'd1);
        wait_done(prev);
        check("stuck_access_count", 64'(acc_total), 64'd150);
        repeat (3) @(negedge clk);
        check("stuck_fail_hold", 64'(fail_o), 64'd1);

        // restart from failed DONE with start_i held through part of RUN
        stuck_en = 1'b0;
        prev = runs_done;
        push_accesses(1000);
        start_run(1'b1, 1'b1, 1'b0, 5'd0, 3'd0);
        check("restart_clears", 64'({done_o, fail_o, fail_addr_o, fail_elem_o}), 64'd0);
        repeat (40) @(posedge clk);
        #1 start_i = 1'b0;
        wait_done(prev);
        check("held_access_count", 64'(acc_total), 64'd150);

        // reset asserted in cycle 60 of a run
        push_accesses(59);
        start_run(1'b0, 1'b0, 1'b0, 5'd0, 3'd0);
        repeat (59) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_bist", 64'(tp.BIST), 64'd0);
        check("midrst_csn", 64'(tp.CSN_T), 64'd1);
        check("midrst_state", 64'({done_o, fail_o, tp.A_T}), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_access_count", 64'(acc_total), 64'd59);
        check("midrst_queue_empty", 64'(acc_q.size()), 64'd0);
        check("midrst_idle_done", 64'(done_o), 64'd0);

        // fresh run after reset
        prev = runs_done;
        push_accesses(1000);
        start_run(1'b0, 1'b1, 1'b0, 5'd0, 3'd0);
        wait_done(prev);
        check("final_access_count", 64'(acc_total), 64'd150);
        check("final_queue_empty", 64'(acc_q.size() + res_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation time %0t expected end of test earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
